// File: rtl/meas_pkg.sv
// Shared constants and entry layout for the measurement result buffer.
// Entries pack as {data, mask, time} with time in the low bits.
package meas_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_CNT_W = 16;
    localparam int TIME_OFF  = 0;

    function automatic int entry_w(input int nq, input int tw);
        return 2 * nq + tw;
    endfunction

    function automatic int mask_off(input int tw);
        return tw;
    endfunction

    function automatic int data_off(input int nq, input int tw);
        return tw + nq;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic first-word-fall-through FIFO with synchronous flush.
// Head is presented combinationally; an empty FIFO reads as zero.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    // A full FIFO still accepts a push when the head leaves this cycle
    assign do_push = push && (!full || do_pop) && !flush;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage array, written synchronously, no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/meas_result_buffer.sv
// Measurement capture buffer: latest-result register file per qubit
// plus a timestamped FIFO history of measurement events.
module meas_result_buffer
    import meas_pkg::*;
#(
    parameter int NUM_QUBITS = 64,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int TS_W       = 64,
    parameter int QIDX_W     = $clog2(NUM_QUBITS),
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     meas_valid,
    input  logic [NUM_QUBITS-1:0]    i_q_measurement,
    input  logic [NUM_QUBITS-1:0]    meas_mask,
    input  logic [TS_W-1:0]          q_time_reg,
    input  logic                     pop,
    output logic                     rd_valid,
    output logic [NUM_QUBITS-1:0]    rd_data,
    output logic [NUM_QUBITS-1:0]    rd_mask,
    output logic [TS_W-1:0]          rd_time,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic [QIDX_W-1:0]        meas_rd_addr,
    output logic                     meas_rd_bit,
    output logic                     meas_rd_known
);

    localparam int EW = entry_w(NUM_QUBITS, TS_W);
    localparam int MO = mask_off(TS_W);
    localparam int DO = data_off(NUM_QUBITS, TS_W);

    logic                  accept;
    logic                  drop;
    logic                  fifo_empty;
    logic [EW-1:0]         wr_entry;
    logic [EW-1:0]         rd_entry;
    logic [NUM_QUBITS-1:0] latest;
    logic [NUM_QUBITS-1:0] known;

    // Events with an empty mask carry nothing and are ignored
    assign accept   = meas_valid && (|meas_mask) && !clear;
    // Full implies non-empty, so a pop here always frees a slot
    assign drop     = accept && full && !pop;
    assign wr_entry = {i_q_measurement & meas_mask, meas_mask, q_time_reg};

    sync_fifo_fwft #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (accept),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .empty (fifo_empty),
        .full  (full),
        .level (level)
    );

    assign rd_valid = !fifo_empty;
    assign rd_data  = rd_entry[DO +: NUM_QUBITS];
    assign rd_mask  = rd_entry[MO +: NUM_QUBITS];
    assign rd_time  = rd_entry[TIME_OFF +: TS_W];

    // Latest-result file; updated even when the FIFO drops the event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latest <= '0;
            known  <= '0;
        end else if (clear) begin
            known  <= '0;
        end else if (accept) begin
            latest <= (latest & ~meas_mask) | (i_q_measurement & meas_mask);
            known  <= known | meas_mask;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    // Latest-result lookup; out-of-range indices read as unknown zero
    always_comb begin
        meas_rd_bit   = 1'b0;
        meas_rd_known = 1'b0;
        if ({1'b0, meas_rd_addr} < (QIDX_W + 1)'(NUM_QUBITS)) begin
            meas_rd_bit   = latest[meas_rd_addr];
            meas_rd_known = known[meas_rd_addr];
        end
    end

endmodule

// File: doc/meas_result_buffer.md
Name: meas_result_buffer

Overview:
- Parametrised capture buffer between the qubit measurement interface and classical_ctrl.
- Successor to the flat 64-bit i_q_measurement input: it adds a per-qubit "latest result" register file, readable by meas_rd_addr, and a timestamped FIFO history of measurement events.
- Captured timestamps come from q_time_reg, so the controller can run branch and feedback instructions on stored results.

Parameters:
- NUM_QUBITS, 64, number of measurement channels.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_W, 64, timestamp width (matches q_time_reg).
- QIDX_W, $clog2(NUM_QUBITS), qubit index width.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush of FIFO, known bits, overflow and drop count.
- meas_valid  in  1  a measurement event is present this cycle.
- i_q_measurement  in  NUM_QUBITS  result bits.
- meas_mask  in  NUM_QUBITS  qubits actually measured in this event.
- q_time_reg  in  TS_W  current quantum time, captured with the event.
- pop  in  1  consume FIFO head.
- rd_valid  out  1  FIFO non-empty; the head is presented first-word-fall-through.
- rd_data  out  NUM_QUBITS  head result bits, already masked.
- rd_mask  out  NUM_QUBITS  head mask.
- rd_time  out  TS_W  head timestamp.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky; an event was dropped.
- drop_cnt  out  CNT_W  dropped events, saturating.
- meas_rd_addr  in  QIDX_W  qubit index for latest-result lookup.
- meas_rd_bit  out  1  latest stored result of the addressed qubit.
- meas_rd_known  out  1  the addressed qubit has been measured since reset or clear.

Behaviour:

Reset (async, rst=1):
- Pointers, level, overflow, drop_cnt, latest[] and known[] all go to 0.
- Therefore rd_valid=0, full=0, and rd_data/rd_mask/rd_time read 0.
- Reset in mid-operation discards all contents immediately.

Accepted event (meas_valid=1 and meas_mask != 0):
- For every q with meas_mask[q]=1: latest[q] <= i_q_measurement[q] and known[q] <= 1. Unmasked qubits keep their values.
- A FIFO entry {i_q_measurement & meas_mask, meas_mask, q_time_reg} is pushed.
- meas_valid with meas_mask=0 is ignored entirely: no push, no update.

Push/pop rules:
- pop while rd_valid=0 is ignored, and level never underflows.
- Push while full with no pop in the same cycle: the entry is dropped, overflow <= 1, drop_cnt increments and saturates at all-ones. latest[]/known[] are still updated.
- Push and pop in the same cycle while full: both succeed and level is unchanged.
- Push and pop in the same cycle while empty: only the push takes effect and level becomes 1.
- Pointers wrap modulo DEPTH.

Latency:
- An event pushed at edge k gives rd_valid=1 with the head data stable from edge k onward. There is no extra read-latency cycle.
- A pop at edge k advances the head at edge k.
- meas_rd_bit and meas_rd_known are combinational muxes of the registered latest[]/known[], so they reflect an update one cycle after the event.

Clear:
- Synchronous and highest priority: empties the FIFO, zeroes known[], overflow and drop_cnt.
- Any meas_valid or pop in the same cycle is ignored.
- latest[] contents may be kept because known[] gates them.

Other rules:
- meas_rd_addr >= NUM_QUBITS returns meas_rd_bit=0 and meas_rd_known=0.
- Storage is inferred as registers or distributed RAM with synchronous write.

Decomposition:
- Shared package meas_pkg holds:
  - the entry-width function (2*NUM_QUBITS+TS_W);
  - field offset constants for data, mask and time;
  - the default DEPTH and CNT_W values.
- One natural sub-module: sync_fifo_fwft (generic width/depth, first-word-fall-through, push/pop/full/empty/level, flush). The top level contains the latest/known register file, the drop and overflow logic, and the lookup mux.

Test Plan:
- Reset then idle: after rst deasserts, rd_valid=0, level=0, overflow=0, and meas_rd_known=0 for addr 0..63.
- Single event (mask=0x5, meas=0xF, time=0x100): next cycle rd_valid=1, rd_data=0x5, rd_mask=0x5, rd_time=0x100; addr 2 gives bit=1/known=1 and addr 1 gives known=0. A pop then returns rd_valid=0 and level=0.
- Fill and overflow: 10 events with times 1..10 and no pops leave level=8, full=1, overflow=1, drop_cnt=2. Popping all 8 yields times 1..8 in order, with latest[] reflecting event 10.
- Full with simultaneous push+pop: level stays 8, head time advances 1→2, the new entry lands at the tail, overflow is unchanged.
- Edge cases:
  - pop while empty: no change.
  - meas_mask=0 with meas_valid: level unchanged.
  - clear together with meas_valid: level=0, known all 0, overflow=0.
  - async rst asserted mid-stream with level=5: outputs go to 0 before the next clock edge.
- Wrap-around: 20 push/pop pairs interleaved at level 3 keep the data order intact across pointer wrap. Drop_cnt saturation is tested with CNT_W overridden to 2: 5 drops leave drop_cnt=3.
